// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the loop.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [4:0]       ALU_CONTROL,
    input  logic [WIDTH-1:0] INPUT_1,
    input  logic [WIDTH-1:0] INPUT_2,
    input  logic             FLUSH,
    output logic             BUSY,
    output logic             DONE,
    output logic             STALL,
    output logic [WIDTH-1:0] RESULT
);

    localparam logic [4:0] OP_DIV  = 5'b01110;
    localparam logic [4:0] OP_DIVU = 5'b01111;
    localparam logic [4:0] OP_REM  = 5'b10000;
    localparam logic [4:0] OP_REMU = 5'b10001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;
    logic             rem_op_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic [WIDTH-1:0] result_r;

    logic             is_div_s;
    logic             signed_op_s;
    logic             rem_op_s;
    logic             in1_neg_s;
    logic             in2_neg_s;
    logic             div_zero_s;
    logic             ovf_s;
    logic             accept_s;
    logic [WIDTH-1:0] special_res_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] rem_n_s;
    logic [WIDTH-1:0] quo_n_s;
    logic [WIDTH-1:0] fin_res_s;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? ({WIDTH{1'b0}} - x) : x;
    endfunction

    // Operation decode, special-case detection and accept qualification
    always_comb begin
        is_div_s    = (ALU_CONTROL == OP_DIV) || (ALU_CONTROL == OP_DIVU) ||
                      (ALU_CONTROL == OP_REM) || (ALU_CONTROL == OP_REMU);
        signed_op_s = (ALU_CONTROL == OP_DIV) || (ALU_CONTROL == OP_REM);
        rem_op_s    = (ALU_CONTROL == OP_REM) || (ALU_CONTROL == OP_REMU);
        in1_neg_s   = signed_op_s & INPUT_1[WIDTH-1];
        in2_neg_s   = signed_op_s & INPUT_2[WIDTH-1];
        div_zero_s  = (INPUT_2 == {WIDTH{1'b0}});
        ovf_s       = signed_op_s && (INPUT_1 == {1'b1, {(WIDTH-1){1'b0}}}) &&
                      (INPUT_2 == {WIDTH{1'b1}});
        accept_s    = (state_r == IDLE) && START && is_div_s && !FLUSH;
        if (div_zero_s) begin
            special_res_s = rem_op_s ? INPUT_1 : {WIDTH{1'b1}};
        end else if (ovf_s) begin
            special_res_s = rem_op_s ? {WIDTH{1'b0}} : {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            special_res_s = {WIDTH{1'b0}};
        end
    end

    // One restoring step plus sign correction of the would-be final result
    always_comb begin
        rem_sh_s = {rem_r, quo_r[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, div_r};
        if (!diff_s[WIDTH]) begin
            rem_n_s = diff_s[WIDTH-1:0];
            quo_n_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_n_s = rem_sh_s[WIDTH-1:0];
            quo_n_s = {quo_r[WIDTH-2:0], 1'b0};
        end
        if (rem_op_r) begin
            fin_res_s = abs_val(rem_n_s, neg_r_r);
        end else begin
            fin_res_s = abs_val(quo_n_s, neg_q_r);
        end
    end

    // Divider control FSM and datapath registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            div_r    <= {WIDTH{1'b0}};
            rem_op_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            result_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && (div_zero_s || ovf_s)) begin
                        result_r <= special_res_s;
                        state_r  <= FIN;
                    end else if (accept_s) begin
                        rem_r    <= {WIDTH{1'b0}};
                        quo_r    <= abs_val(INPUT_1, in1_neg_s);
                        div_r    <= abs_val(INPUT_2, in2_neg_s);
                        cnt_r    <= CNT_W'(WIDTH - 1);
                        rem_op_r <= rem_op_s;
                        neg_q_r  <= in1_neg_s ^ in2_neg_s;
                        neg_r_r  <= in1_neg_s;
                        state_r  <= CALC;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                CALC: begin
                    if (FLUSH) begin
                        state_r <= IDLE;
                    end else begin
                        rem_r <= rem_n_s;
                        quo_r <= quo_n_s;
                        if (cnt_r == {CNT_W{1'b0}}) begin
                            result_r <= fin_res_s;
                            state_r  <= FIN;
                        end else begin
                            cnt_r <= cnt_r - CNT_W'(1);
                        end
                    end
                end
                FIN: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign BUSY   = (state_r != IDLE);
    assign DONE   = (state_r == FIN) && !FLUSH;
    assign STALL  = accept_s || (BUSY && !DONE);
    assign RESULT = result_r;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: hand-computed quotients,
// remainders, latencies and stall/flush/reset behaviour.
module tb_div_unit;

    localparam logic [4:0] OP_DIV  = 5'b01110;
    localparam logic [4:0] OP_DIVU = 5'b01111;
    localparam logic [4:0] OP_REM  = 5'b10000;
    localparam logic [4:0] OP_REMU = 5'b10001;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        START;
    logic [4:0]  ALU_CONTROL;
    logic [31:0] INPUT_1;
    logic [31:0] INPUT_2;
    logic        FLUSH;
    logic        BUSY;
    logic        DONE;
    logic        STALL;
    logic [31:0] RESULT;

    int tests = 0;
    int fails = 0;

    div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .ALU_CONTROL(ALU_CONTROL),
        .INPUT_1(INPUT_1), .INPUT_2(INPUT_2), .FLUSH(FLUSH),
        .BUSY(BUSY), .DONE(DONE), .STALL(STALL), .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // n = 1 means the cycle right after the accepting edge
    task automatic wait_done(output int n);
        n = 1;
        while (DONE !== 1'b1 && n < 60) begin
            @(negedge CLK);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int n;
        @(negedge CLK);
        START = 1'b1; ALU_CONTROL = op; INPUT_1 = a; INPUT_2 = b;
        #1;
        chk({tag, "_stall_acc"}, {31'd0, STALL}, 32'd1);
        @(negedge CLK);
        START = 1'b0;
        #1;
        chk({tag, "_busy"}, {31'd0, BUSY}, 32'd1);
        if (exp_lat > 1) chk({tag, "_stall_calc"}, {31'd0, STALL}, 32'd1);
        wait_done(n);
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_res"}, RESULT, exp);
        chk({tag, "_stall_done"}, {31'd0, STALL}, 32'd0);
        @(negedge CLK);
        #1;
        chk({tag, "_done_pulse"}, {31'd0, DONE}, 32'd0);
        chk({tag, "_idle"}, {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        int n;
        RESET_N = 1'b0; START = 1'b0; ALU_CONTROL = 5'd0;
        INPUT_1 = 32'd0; INPUT_2 = 32'd0; FLUSH = 1'b0;
        #12;
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_result", RESULT, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("divu_big_ovfpat", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
        run_op("divu_3_10", OP_DIVU, 32'd3, 32'd10, 32'd0, 33);
        run_op("remu_3_10", OP_REMU, 32'd3, 32'd10, 32'd3, 33);

        // START held high; operand change mid-CALC must not affect the result
        @(negedge CLK);
        START = 1'b1; ALU_CONTROL = OP_DIVU; INPUT_1 = 32'd100; INPUT_2 = 32'd7;
        @(negedge CLK);
        #1;
        INPUT_1 = 32'd1000;
        wait_done(n);
        chk("hold_lat", 32'(n), 32'd33);
        chk("hold_res", RESULT, 32'd14);
        @(negedge CLK);
        #1;
        chk("hold_single_done", {31'd0, DONE}, 32'd0);
        chk("hold_idle", {31'd0, BUSY}, 32'd0);
        chk("hold_reaccept_stall", {31'd0, STALL}, 32'd1);
        @(negedge CLK);
        START = 1'b0;
        #1;
        chk("hold_reaccept_busy", {31'd0, BUSY}, 32'd1);
        wait_done(n);
        chk("hold2_lat", 32'(n), 32'd33);
        chk("hold2_res", RESULT, 32'd142);

        // Non-divide op code is ignored
        @(negedge CLK);
        START = 1'b1; ALU_CONTROL = 5'b00010;
        #1;
        chk("badop_stall", {31'd0, STALL}, 32'd0);
        @(negedge CLK);
        #1;
        chk("badop_busy", {31'd0, BUSY}, 32'd0);
        START = 1'b0;

        // FLUSH together with START in IDLE: not accepted
        @(negedge CLK);
        START = 1'b1; FLUSH = 1'b1; ALU_CONTROL = OP_DIVU; INPUT_1 = 32'd50; INPUT_2 = 32'd5;
        #1;
        chk("flush_start_stall", {31'd0, STALL}, 32'd0);
        @(negedge CLK);
        #1;
        chk("flush_start_busy", {31'd0, BUSY}, 32'd0);
        START = 1'b0; FLUSH = 1'b0;

        // FLUSH at CALC cycle 10
        @(negedge CLK);
        START = 1'b1; ALU_CONTROL = OP_DIVU; INPUT_1 = 32'd50; INPUT_2 = 32'd5;
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        FLUSH = 1'b1;
        #1;
        chk("flush_done_forced", {31'd0, DONE}, 32'd0);
        @(negedge CLK);
        FLUSH = 1'b0;
        #1;
        chk("flush_idle", {31'd0, BUSY}, 32'd0);
        chk("flush_result_kept", RESULT, 32'd142);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            #1;
            if (DONE === 1'b1) n++;
        end
        chk("flush_no_done", 32'(n), 32'd0);

        // Async reset mid-operation
        @(negedge CLK);
        START = 1'b1; ALU_CONTROL = OP_DIVU; INPUT_1 = 32'd100; INPUT_2 = 32'd7;
        @(negedge CLK);
        START = 1'b0;
        repeat (19) @(negedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, BUSY}, 32'd0);
        chk("mid_rst_done", {31'd0, DONE}, 32'd0);
        chk("mid_rst_result", RESULT, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
